mem_arb: RTL and testbench
==========================

# mem_arb

Parametrised round-robin arbiter for the processor's single external memory port. It lets NCH masters share one `mem_read`/`mem_write` interface: instruction fetch, data access, and later DMA or debug. Each transaction uses a request/acknowledge handshake with the master, and a completion handshake (`mem_ready`) with external memory. A watchdog ends any access that memory never completes, so a hung memory cannot hang the pipeline.

## Interface
- NCH, 2, number of master channels (≥2)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, max BUSY cycles waiting for `mem_ready` before error completion (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NCH  per-channel request; held until `ack` of that channel
- we  in  NCH  per-channel write enable (1 = write, 0 = read); stable while `req`
- addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
- wdata  in  NCH*DW  per-channel write data, same packing
- ack  out  NCH  one-hot, one-cycle completion pulse to the served channel
- err  out  1  valid with `ack`: 1 = timed out
- rdata  out  DW  read data, valid with `ack` for reads; 0 on error or write
- mem_read  out  1  external read strobe, held for the whole access
- mem_write  out  1  external write strobe, held for the whole access
- mem_addr  out  AW  external address
- mem_wdata  out  DW  external write data
- mem_rdata  in  DW  external read data, sampled on the `mem_ready` edge
- mem_ready  in  1  external completion, one cycle, meaningful only in BUSY

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no `req`: stay in IDLE.
- IDLE, any `req` bit set:
  - Select a channel round-robin, searching upward from `ptr` and wrapping NCH-1 → 0.
  - Latch the selected channel index.
  - Register `mem_addr`, `mem_wdata`, and `mem_read = ~we` / `mem_write = we` from that channel.
  - Clear the watchdog counter, then enter BUSY.
- BUSY with `mem_ready=1`:
  - Capture `mem_rdata` (reads only, else 0) into `rdata`.
  - Set `ack[ch]=1`, `err=0`, drop `mem_read`/`mem_write`, enter DONE.
- BUSY, counter = TIMEOUT-1, no `mem_ready`: set `ack[ch]=1`, `err=1`, `rdata=0`, drop the strobes, enter DONE.
- BUSY otherwise: counter +1; all outputs hold.
- DONE:
  - Clear `ack` and `err`; `rdata` holds.
  - Set `ptr = ch+1` mod NCH, then enter IDLE.
  - `req` is not sampled in DONE, which gives the master one cycle to drop `req`.
- `ptr` advances only on completion, including error completion. A channel requesting continuously is therefore served at most once per NCH grants while others wait (starvation-free).
- `mem_ready` outside BUSY: ignored.
- `req` deasserted while the channel is in BUSY: protocol violation. The access still completes and `ack` is still issued.
- Counter width: $clog2(TIMEOUT).

## Timing
- Reset values: state IDLE, `ptr=0`, `ack=0`, `err=0`, `rdata=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `req` seen at edge N → strobes high from N+1.
- First `mem_ready` seen at edge N+k (k≥1) → `ack` high during cycle N+k+1.
- Minimum occupancy: 3 cycles (IDLE→BUSY→DONE→IDLE). Peak throughput: one access per 3 cycles.
- Timeout: `ack`/`err` rise TIMEOUT cycles after the strobes rise.
- Reset asserted mid-access: immediate return to reset values. The external access is abandoned and no `ack` is issued.

## Structure
- Shared `defines.v` additions:
  - ARB_IDLE/ARB_BUSY/ARB_DONE 2-bit encodings.
  - MEM_TIMEOUT_DEFAULT.
- One sub-module, `rr_pick`: combinational. Inputs: NCH-wide `req` and `ptr`. Outputs: grant index and `any`. Instantiated once.
- The FSM, watchdog counter, and output registers live in `mem_arb`.

## Test plan
- Reset: assert `rst` mid-BUSY → all outputs 0 in the same cycle, no `ack`; after release, `req[1]` read of 0x40, `mem_ready` two cycles later with `mem_rdata=0xDEADBEEF` → `ack=2'b10`, `rdata=0xDEADBEEF`, `err=0`.
- Write: `req[0]`, `we[0]=1`, `addr=0x100`, `wdata=0x1234` → `mem_write=1`, `mem_addr=0x100`, `mem_wdata=0x1234` from the next cycle; `mem_ready` → `ack=2'b01`, `rdata=0`.
- Fairness, NCH=3: all three `req` held, each re-raised after its `ack` → grant order 0,1,2,0,1,2; no channel is served twice in a row.
- Simultaneous: `req[0]` and `req[1]` rise together at reset (`ptr=0`) → channel 0 first; channel 1 strobes start 3 cycles after channel 0's `mem_ready`.
- Timeout, TIMEOUT=8: `mem_ready` never asserted → `ack` with `err=1`, `rdata=0`, exactly 8 cycles after the strobes rise; the next request is served normally.
- Stray `mem_ready` pulses in IDLE and DONE → no state change, no `ack`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick: first requesting channel at or above ptr, wrapping.
module rr_pick #(
    parameter int NCH = 2,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [PW-1:0]  grant,
    output logic           any
);

    localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

    logic [PW:0] sum;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            // ptr + i < 2*NCH, so one conditional subtraction is a full modulo
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= NCH_W) begin
                sum = sum - NCH_W;
            end
            if (!any && req[sum[PW-1:0]]) begin
                grant = sum[PW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one external memory port among NCH masters,
// with a watchdog that error-completes accesses memory never finishes.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    ack,
    output logic              err,
    output logic [DW-1:0]     rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready
);

    localparam int PW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] CH_LAST  = PW'(NCH - 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ch;
    logic [CW-1:0] cnt;
    logic [PW-1:0] grant;
    logic          any;

    rr_pick #(
        .NCH (NCH),
        .PW  (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .any   (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            ch        <= '0;
            cnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        ch        <= grant;
                        mem_addr  <= addr[grant*AW +: AW];
                        mem_wdata <= wdata[grant*DW +: DW];
                        mem_read  <= ~we[grant];
                        mem_write <= we[grant];
                        cnt       <= '0;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready) begin
                        rdata     <= mem_read ? mem_rdata : '0;
                        ack[ch]   <= 1'b1;
                        err       <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ARB_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata     <= '0;
                        ack[ch]   <= 1'b1;
                        err       <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ARB_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    // req is not sampled here, giving the master a cycle to drop it
                    ack   <= '0;
                    err   <= 1'b0;
                    ptr   <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb (NCH=3, TIMEOUT=8).
module tb_mem_arb;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    we = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic [NCH-1:0]    ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mem_arb #(
        .NCH     (NCH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int unsigned c, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        we[c]             = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    task automatic wait_strobe(input string tag);
        int unsigned n = 0;
        while (!(mem_read || mem_write) && n < 6) begin
            step();
            n++;
        end
        check(tag, {63'b0, mem_read | mem_write}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [2:0]  oh;
        int unsigned early;

        // reset values
        step();
        step();
        check("rst_ack", ack, 3'b000);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rd", mem_read, 0);
        check("rst_wr", mem_write, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        // reset asserted mid-BUSY
        set_ch(0, 1'b0, 32'h20, 32'h0);
        req = 3'b001;
        step();
        check("mid_rd_on", mem_read, 1);
        check("mid_addr", mem_addr, 32'h20);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rd", mem_read, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_ack", ack, 3'b000);
        req = '0;
        step();
        rst = 1'b0;
        step();
        step();
        check("mid_after_ack", ack, 3'b000);
        check("mid_after_rd", mem_read, 0);

        // channel 1 read, mem_ready two cycles after strobes
        set_ch(1, 1'b0, 32'h40, 32'h0);
        req = 3'b010;
        step();
        check("rd1_strobe", mem_read, 1);
        check("rd1_addr", mem_addr, 32'h40);
        check("rd1_noack", ack, 3'b000);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        check("rd1_ack", ack, 3'b010);
        check("rd1_rdata", rdata, 32'hDEADBEEF);
        check("rd1_err", err, 0);
        check("rd1_drop", mem_read, 0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        req = '0;
        step();
        check("rd1_done_ack", ack, 3'b000);
        check("rd1_hold", rdata, 32'hDEADBEEF);

        // watchdog timeout on channel 2
        set_ch(2, 1'b0, 32'h300, 32'h0);
        req = 3'b100;
        step();
        check("to_strobe", mem_read, 1);
        check("to_addr", mem_addr, 32'h300);
        early = 0;
        repeat (TO - 1) begin
            step();
            if (ack != 3'b000) early++;
        end
        check("to_early", early, 0);
        step();
        check("to_ack", ack, 3'b100);
        check("to_err", err, 1);
        check("to_rdata", rdata, 0);
        check("to_drop", mem_read, 0);
        req = '0;
        step();
        check("to_done_ack", ack, 3'b000);
        check("to_done_err", err, 0);

        // write on channel 0, then stray mem_ready in DONE and IDLE
        set_ch(0, 1'b1, 32'h100, 32'h1234);
        req = 3'b001;
        step();
        check("wr_strobe", mem_write, 1);
        check("wr_nord", mem_read, 0);
        check("wr_addr", mem_addr, 32'h100);
        check("wr_wdata", mem_wdata, 32'h1234);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        check("wr_ack", ack, 3'b001);
        check("wr_rdata", rdata, 0);
        check("wr_err", err, 0);
        check("wr_drop", mem_write, 0);
        req = '0;
        step();
        check("stray_done_ack", ack, 3'b000);
        check("stray_done_wr", mem_write, 0);
        step();
        check("stray_idle_ack", ack, 3'b000);
        check("stray_idle_rd", mem_read, 0);
        check("stray_idle_wr", mem_write, 0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        set_ch(0, 1'b0, 32'h0, 32'h0);

        // simultaneous requests right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ch(0, 1'b0, 32'h10, 32'h0);
        set_ch(1, 1'b0, 32'h14, 32'h0);
        req = 3'b011;
        step();
        check("sim_first_rd", mem_read, 1);
        check("sim_first_addr", mem_addr, 32'h10);
        mem_ready = 1'b1;
        mem_rdata = 32'h11;
        step();
        check("sim_ack0", ack, 3'b001);
        check("sim_rdata0", rdata, 32'h11);
        mem_ready = 1'b0;
        req = 3'b010;
        step();
        check("sim_gap1", mem_read, 0);
        step();
        check("sim_second_rd", mem_read, 1);
        check("sim_second_addr", mem_addr, 32'h14);
        mem_ready = 1'b1;
        mem_rdata = 32'h22;
        step();
        check("sim_ack1", ack, 3'b010);
        check("sim_rdata1", rdata, 32'h22);
        mem_ready = 1'b0;
        req = '0;
        step();

        // fairness with all three channels requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            set_ch(c, 1'b0, 32'h1000 + 32'(4 * c), 32'h0);
        end
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            int exp_ch;
            exp_ch = g % NCH;
            oh = 3'b001 << exp_ch;
            wait_strobe($sformatf("rr%0d_strobe", g));
            check($sformatf("rr%0d_addr", g), mem_addr, 32'h1000 + 32'(4 * exp_ch));
            mem_ready = 1'b1;
            mem_rdata = 32'(g);
            step();
            check($sformatf("rr%0d_ack", g), ack, oh);
            mem_ready = 1'b0;
            req[exp_ch] = 1'b0;
            step();
            req[exp_ch] = 1'b1;
        end
        req = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
